handshake_loop_profiler: RTL and testbench
==========================================

Name: handshake_loop_profiler

Overview:
- Synthesizable cycle-accurate activity profiler for HLS-generated blocks.
- Observes one block-level ap_start/ap_ready/ap_done/ap_continue handshake and one pipelined-loop control interface (FSM state, stage block, stage enables, loop start/ready/done).
- Produces saturating event and cycle counters plus a status state.
- Sits beside the DUT in the top level as a passive, read-only observer. It never drives DUT signals.

Parameters:
- STATE_W, 1, width of the observed loop FSM state vectors.
- CNT_W, 32, width of every counter output.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- finish  in  1  end of observation; freezes all counters and state.
- ap_start  in  1  block start.
- ap_ready  in  1  block ready (accepts new input).
- ap_done  in  1  block done.
- ap_continue  in  1  downstream continue; tie to 1 when unused.
- cur_state  in  STATE_W  loop FSM current state.
- iter_start_state  in  STATE_W  state in which an iteration starts.
- iter_end_state  in  STATE_W  state in which an iteration ends.
- quit_state  in  STATE_W  state in which the loop exits.
- iter_start_block  in  1  stage stall at iteration start (1 = stalled).
- iter_end_block  in  1  stage stall at iteration end.
- quit_block  in  1  stage stall at exit.
- iter_start_enable  in  1  first pipeline-stage enable.
- iter_end_enable  in  1  last pipeline-stage enable.
- quit_enable  in  1  enable qualifying exit.
- loop_start  in  1  loop invocation start.
- loop_ready  in  1  loop ready.
- loop_done  in  1  loop done.
- loop_continue  in  1  loop continue.
- quit_at_end  in  1  1 = exit coincides with last iteration end.
- mod_state  out  2  0 IDLE, 1 BUSY, 2 WAIT_CONT, 3 FROZEN.
- mod_start_cnt  out  CNT_W  accepted block starts.
- mod_done_cnt  out  CNT_W  completed block runs.
- mod_busy_cycles  out  CNT_W  cycles spent in BUSY.
- mod_last_latency  out  CNT_W  cycles from start to done of the most recent run.
- iter_start_cnt  out  CNT_W  iterations started.
- iter_end_cnt  out  CNT_W  iterations finished.
- loop_inv_cnt  out  CNT_W  loop invocations completed.
- loop_last_cycles  out  CNT_W  duration of the last loop invocation.
- min_ii  out  CNT_W  minimum initiation interval; see Optional Feature.

Behaviour:
- Reset: all outputs are 0 and mod_state is IDLE. Reset asserted mid-run aborts any in-progress measurement with no partial update.

Block state machine:
- IDLE to BUSY when ap_start=1. mod_start_cnt increments and the latency timer loads 1.
- In BUSY, mod_busy_cycles increments every cycle and the timer increments.
- BUSY exit on ap_done=1:
  - mod_done_cnt increments and mod_last_latency is set to the timer value.
  - If ap_continue=1: go to IDLE, or stay in BUSY with a new start counted and the timer reloaded to 1 if ap_start=1 in the same cycle.
  - If ap_continue=0: go to WAIT_CONT.
- WAIT_CONT to IDLE when ap_continue=1. No counting occurs in WAIT_CONT.
- ap_ready is observed only. It does not affect the state machine.

Loop events (evaluated every cycle):
- Iteration start: cur_state==iter_start_state, iter_start_block=0 and iter_start_enable=1. iter_start_cnt increments.
- Iteration end: cur_state==iter_end_state, iter_end_block=0 and iter_end_enable=1. iter_end_cnt increments.
- Quit: cur_state==quit_state, quit_block=0, quit_enable=1 and loop_done=1.
- Both start and end events in one cycle increment both counters.

Loop invocation:
- Active from the loop_start rising cycle until the quit event.
- On quit: loop_inv_cnt increments and loop_last_cycles is set to the cycles elapsed, inclusive of both ends.
- If quit_at_end=1, the quit event also counts as an iteration end only when the end event did not already fire in that cycle. No double count.
- A new invocation cannot begin until the next cycle after quit with loop_continue=1.

Counter rules:
- All counters saturate at 2^CNT_W-1 and never wrap.

Finish:
- finish=1 moves mod_state to FROZEN on the next edge. All outputs then hold until reset.
- finish has priority over every other event in the same cycle; that cycle's events are not counted.

Optional Feature:
- Macro: PROFILER_MIN_II_EN.
- When defined: track cycles between consecutive iteration-start events within one invocation. min_ii holds the smallest gap seen.
  - min_ii is 0 until the second start event.
  - The gap measurement resets at each new invocation; min_ii itself is not cleared.
  - An II of 1 (back-to-back starts) reports 1.
- When undefined: min_ii is constant 0 and no II logic is synthesized.

Test Plan:
- Reset/idle: reset high for 3 cycles, then idle for 10 cycles -> all counters 0, mod_state=0.
- Single run: ap_start pulse at cycle 5, ap_done at cycle 12, ap_continue=1 -> mod_start_cnt=1, mod_done_cnt=1, mod_last_latency=8, mod_busy_cycles=8.
- Back-pressure: ap_done with ap_continue=0 for 4 cycles -> mod_state=2 for 4 cycles, busy count unchanged, then IDLE.
- Pipelined loop:
  - Stimulus: 6 iterations at II=1, depth 4 (iter_end_enable lags 3 cycles), quit with quit_at_end=1.
  - Response: iter_start_cnt=6, iter_end_cnt=6, loop_inv_cnt=1, min_ii=1 (with PROFILER_MIN_II_EN).
- Stall: iter_start_block=1 for 2 cycles mid-loop -> no starts counted during the stall; with PROFILER_MIN_II_EN, min_ii stays 1 from the earlier starts.
- Finish/saturation:
  - CNT_W=4, 20 iterations -> iter_start_cnt=15.
  - Assert finish -> mod_state=3 and values hold despite further stimulus.

Source files
------------

// File: rtl/handshake_loop_profiler.sv
// Passive activity profiler for an HLS block handshake and one pipelined loop.
// Optional minimum-II tracking is compiled in with `define PROFILER_MIN_II_EN.
module handshake_loop_profiler #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic [1:0]         mod_state,
  output logic [CNT_W-1:0]   mod_start_cnt,
  output logic [CNT_W-1:0]   mod_done_cnt,
  output logic [CNT_W-1:0]   mod_busy_cycles,
  output logic [CNT_W-1:0]   mod_last_latency,
  output logic [CNT_W-1:0]   iter_start_cnt,
  output logic [CNT_W-1:0]   iter_end_cnt,
  output logic [CNT_W-1:0]   loop_inv_cnt,
  output logic [CNT_W-1:0]   loop_last_cycles,
  output logic [CNT_W-1:0]   min_ii
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_WAIT   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  state_t           state, state_next;
  logic             accept_start, run_done, in_busy, freeze;
  logic [CNT_W-1:0] timer;

  // Handshake ready signals are observed only; they never steer the profiler.
  logic unused_inputs;
  assign unused_inputs = ap_ready ^ loop_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (finish) begin
      state_next = S_FROZEN;
    end else begin
      case (state)
        S_IDLE:  if (ap_start) state_next = S_BUSY;
        S_BUSY:  if (ap_done) state_next = ap_continue ? (ap_start ? S_BUSY : S_IDLE) : S_WAIT;
        S_WAIT:  if (ap_continue) state_next = S_IDLE;
        default: state_next = S_FROZEN;
      endcase
    end
  end

  // The accepting cycle itself counts as the first busy cycle of a run.
  always_comb begin
    mod_state    = state;
    accept_start = 1'b0;
    run_done     = 1'b0;
    in_busy      = 1'b0;
    if (!finish) begin
      case (state)
        S_IDLE: accept_start = ap_start;
        S_BUSY: begin
          in_busy      = 1'b1;
          run_done     = ap_done;
          accept_start = ap_done & ap_continue & ap_start;
        end
        default: ;
      endcase
    end
  end

  assign freeze = finish | (state == S_FROZEN);

  always_ff @(posedge clock) begin
    if (reset) begin
      mod_start_cnt    <= '0;
      mod_done_cnt     <= '0;
      mod_busy_cycles  <= '0;
      mod_last_latency <= '0;
      timer            <= '0;
    end else begin
      if (accept_start) mod_start_cnt <= sat_inc(mod_start_cnt);
      if (run_done) begin
        mod_done_cnt     <= sat_inc(mod_done_cnt);
        mod_last_latency <= sat_inc(timer);
      end
      if (accept_start | in_busy) mod_busy_cycles <= sat_inc(mod_busy_cycles);
      if (accept_start)  timer <= ONE;
      else if (in_busy)  timer <= sat_inc(timer);
    end
  end

  logic             start_ev, end_ev, quit_raw, quit_ev, end_total;
  logic             begin_inv, in_inv, loop_active, loop_hold;
  logic [CNT_W-1:0] loop_timer;

  assign start_ev  = ~freeze & (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
  assign end_ev    = ~freeze & (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
  assign quit_raw  = ~freeze & (cur_state == quit_state) & ~quit_block & quit_enable & loop_done;
  // After a quit, a new invocation waits for loop_continue in a later cycle.
  assign begin_inv = ~freeze & ~loop_active & loop_start & (~loop_hold | loop_continue);
  assign in_inv    = loop_active | begin_inv;
  assign quit_ev   = quit_raw & in_inv;
  assign end_total = end_ev | (quit_ev & quit_at_end);

  always_ff @(posedge clock) begin
    if (reset) begin
      iter_start_cnt   <= '0;
      iter_end_cnt     <= '0;
      loop_inv_cnt     <= '0;
      loop_last_cycles <= '0;
      loop_timer       <= '0;
      loop_active      <= 1'b0;
      loop_hold        <= 1'b0;
    end else begin
      if (start_ev)  iter_start_cnt <= sat_inc(iter_start_cnt);
      if (end_total) iter_end_cnt   <= sat_inc(iter_end_cnt);
      if (!freeze && loop_continue) loop_hold <= 1'b0;
      if (quit_ev) begin
        loop_active      <= 1'b0;
        loop_hold        <= 1'b1;
        loop_inv_cnt     <= sat_inc(loop_inv_cnt);
        loop_last_cycles <= begin_inv ? ONE : sat_inc(loop_timer);
      end else if (begin_inv) begin
        loop_active <= 1'b1;
        loop_hold   <= 1'b0;
        loop_timer  <= ONE;
      end else if (loop_active && !freeze) begin
        loop_timer <= sat_inc(loop_timer);
      end
    end
  end

`ifdef PROFILER_MIN_II_EN
  logic [CNT_W-1:0] gap_cnt, min_ii_q;
  logic             have_prev, prev_valid;

  // A start in the invocation's first cycle has no predecessor to measure from.
  assign prev_valid = have_prev & ~begin_inv;

  always_ff @(posedge clock) begin
    if (reset) begin
      gap_cnt   <= '0;
      min_ii_q  <= '0;
      have_prev <= 1'b0;
    end else if (!freeze) begin
      if (begin_inv) have_prev <= 1'b0;
      if (in_inv && start_ev) begin
        if (prev_valid && (min_ii_q == '0 || gap_cnt < min_ii_q)) min_ii_q <= gap_cnt;
        gap_cnt   <= ONE;
        have_prev <= 1'b1;
      end else begin
        gap_cnt <= sat_inc(gap_cnt);
      end
    end
  end

  assign min_ii = min_ii_q;
`else
  assign min_ii = '0;
`endif

endmodule

// File: tb/tb_handshake_loop_profiler.sv
// Directed bench for handshake_loop_profiler: block FSM, loop events, stalls,
// saturation (second instance with CNT_W=4) and finish freeze.
module tb_handshake_loop_profiler;

`ifdef PROFILER_MIN_II_EN
  localparam int EXP_MIN_II = 1;
`else
  localparam int EXP_MIN_II = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       finish = 1'b0;
  logic       ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
  logic [0:0] cur_state = 1'b0, iter_start_state = 1'b0, iter_end_state = 1'b0, quit_state = 1'b0;
  logic       iter_start_block = 1'b0, iter_end_block = 1'b0, quit_block = 1'b0;
  logic       iter_start_enable = 1'b0, iter_end_enable = 1'b0, quit_enable = 1'b0;
  logic       loop_start = 1'b0, loop_ready = 1'b0, loop_done = 1'b0, loop_continue = 1'b1;
  logic       quit_at_end = 1'b1;

  logic [1:0]  mod_state, mod_state4;
  logic [31:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_last_latency;
  logic [31:0] iter_start_cnt, iter_end_cnt, loop_inv_cnt, loop_last_cycles, min_ii;
  logic [3:0]  mod_start_cnt4, mod_done_cnt4, mod_busy_cycles4, mod_last_latency4;
  logic [3:0]  iter_start_cnt4, iter_end_cnt4, loop_inv_cnt4, loop_last_cycles4, min_ii4;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  handshake_loop_profiler #(.STATE_W(1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .quit_state(quit_state), .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_state(mod_state), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
    .mod_busy_cycles(mod_busy_cycles), .mod_last_latency(mod_last_latency),
    .iter_start_cnt(iter_start_cnt), .iter_end_cnt(iter_end_cnt), .loop_inv_cnt(loop_inv_cnt),
    .loop_last_cycles(loop_last_cycles), .min_ii(min_ii)
  );

  handshake_loop_profiler #(.STATE_W(1), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .quit_state(quit_state), .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .quit_block(quit_block), .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .quit_enable(quit_enable), .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_state(mod_state4), .mod_start_cnt(mod_start_cnt4), .mod_done_cnt(mod_done_cnt4),
    .mod_busy_cycles(mod_busy_cycles4), .mod_last_latency(mod_last_latency4),
    .iter_start_cnt(iter_start_cnt4), .iter_end_cnt(iter_end_cnt4), .loop_inv_cnt(loop_inv_cnt4),
    .loop_last_cycles(loop_last_cycles4), .min_ii(min_ii4)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(10);
    check("reset_state", 32'(mod_state), 0);
    check("reset_start_cnt", mod_start_cnt, 0);
    check("reset_done_cnt", mod_done_cnt, 0);
    check("reset_busy", mod_busy_cycles, 0);
    check("reset_iter_start", iter_start_cnt, 0);
    check("reset_loop_inv", loop_inv_cnt, 0);
    check("reset_min_ii", min_ii, 0);

    // Single run: start cycle through done cycle is 8 cycles
    ap_continue = 1'b1;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    check("run_busy_state", 32'(mod_state), 1);
    check("run_start_cnt", mod_start_cnt, 1);
    tick(6);
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("run_done_cnt", mod_done_cnt, 1);
    check("run_latency", mod_last_latency, 8);
    check("run_busy", mod_busy_cycles, 8);
    check("run_idle", 32'(mod_state), 0);

    // Back-pressure: done with continue low holds WAIT_CONT for 4 cycles
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick(2);
    ap_done = 1'b1;
    ap_continue = 1'b0;
    tick();
    ap_done = 1'b0;
    check("bp_latency", mod_last_latency, 4);
    check("bp_done_cnt", mod_done_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      check("bp_wait_state", 32'(mod_state), 2);
      check("bp_busy_hold", mod_busy_cycles, 12);
      if (i < 3) tick();
    end
    ap_continue = 1'b1;
    tick();
    check("bp_idle", 32'(mod_state), 0);
    check("bp_busy_final", mod_busy_cycles, 12);

    // Done and restart in the same cycle
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    tick();
    ap_done = 1'b1;
    ap_start = 1'b1;
    tick();
    ap_done = 1'b0;
    ap_start = 1'b0;
    check("rs_state", 32'(mod_state), 1);
    check("rs_start_cnt", mod_start_cnt, 4);
    check("rs_latency", mod_last_latency, 3);
    tick();
    ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("rs_latency2", mod_last_latency, 3);
    check("rs_done_cnt", mod_done_cnt, 4);
    check("rs_busy", mod_busy_cycles, 17);
    check("rs_busy_sat4", 32'(mod_busy_cycles4), 15);

    // Pipelined loop: 6 starts at II=1, ends lag 3, quit supplies the 6th end
    for (int c = 0; c <= 8; c++) begin
      loop_start        = (c == 0);
      iter_start_enable = (c <= 5);
      iter_end_enable   = (c >= 3 && c <= 7);
      quit_enable       = (c == 8);
      loop_done         = (c == 8);
      tick();
      if (c == 0) check("loop_min_ii_first", min_ii, 0);
      if (c == 1) check("loop_min_ii_second", min_ii, EXP_MIN_II);
    end
    loop_start = 1'b0; iter_start_enable = 1'b0; iter_end_enable = 1'b0;
    quit_enable = 1'b0; loop_done = 1'b0;
    tick();
    check("loop_iter_start", iter_start_cnt, 6);
    check("loop_iter_end", iter_end_cnt, 6);
    check("loop_inv", loop_inv_cnt, 1);
    check("loop_cycles", loop_last_cycles, 9);
    check("loop_min_ii", min_ii, EXP_MIN_II);

    // Stall mid-loop; quit coincides with an end event (no double count)
    for (int c = 0; c <= 6; c++) begin
      loop_start        = (c == 0);
      iter_start_enable = (c <= 5);
      iter_start_block  = (c == 2 || c == 3);
      iter_end_enable   = (c >= 3);
      quit_enable       = (c == 6);
      loop_done         = (c == 6);
      tick();
      if (c == 3) check("stall_no_starts", iter_start_cnt, 8);
    end
    loop_start = 1'b0; iter_start_enable = 1'b0; iter_start_block = 1'b0;
    iter_end_enable = 1'b0; quit_enable = 1'b0; loop_done = 1'b0;
    tick();
    check("stall_iter_start", iter_start_cnt, 10);
    check("stall_iter_end", iter_end_cnt, 10);
    check("stall_inv", loop_inv_cnt, 2);
    check("stall_cycles", loop_last_cycles, 7);
    check("stall_min_ii", min_ii, EXP_MIN_II);

    // Saturation: 20 starts against a 4-bit counter
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      loop_start        = (c == 0);
      iter_start_enable = 1'b1;
      tick();
    end
    loop_start = 1'b0;
    check("sat_iter_start32", iter_start_cnt, 20);
    check("sat_iter_start4", 32'(iter_start_cnt4), 15);

    // Finish wins over same-cycle events, then everything holds
    finish = 1'b1;
    ap_start = 1'b1;
    tick();
    finish = 1'b0;
    check("fin_state", 32'(mod_state), 3);
    check("fin_state4", 32'(mod_state4), 3);
    check("fin_iter_start", iter_start_cnt, 20);
    check("fin_start_cnt", mod_start_cnt, 0);
    tick(5);
    check("frz_state", 32'(mod_state), 3);
    check("frz_iter_start", iter_start_cnt, 20);
    check("frz_iter_start4", 32'(iter_start_cnt4), 15);
    check("frz_start_cnt", mod_start_cnt, 0);
    check("frz_busy", mod_busy_cycles, 0);
    ap_start = 1'b0;
    iter_start_enable = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_state", 32'(mod_state), 0);
    check("post_reset_iter", iter_start_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
